// File: rtl/branch_outcome_queue.sv
// In-order branch tracking queue between fetch-time prediction and execute-time resolution.
// Optional saturating resolve/mispredict statistics are enabled with macro BOQ_STATS_EN.
module branch_outcome_queue #(
    parameter int PC_WIDTH  = 8,
    parameter int GHR_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [PC_WIDTH-1:0]          alloc_pc,
    input  logic                         alloc_pred,
    input  logic [GHR_WIDTH-1:0]         alloc_ghr,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    output logic                         upd_valid,
    output logic [PC_WIDTH-1:0]          upd_pc,
    output logic                         upd_taken,
    output logic [GHR_WIDTH-1:0]         upd_ghr,
    output logic                         mispredict,
    output logic [GHR_WIDTH-1:0]         repair_ghr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         underflow
`ifdef BOQ_STATS_EN
    ,
    output logic [15:0]                  stat_resolved,
    output logic [15:0]                  stat_mispred
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];
    logic                 pred_mem [DEPTH];
    logic [GHR_WIDTH-1:0] ghr_mem  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_alloc;
    logic          do_pop;
    logic          head_mis;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_pop      = resolve_valid && !empty;
    assign head_mis    = do_pop && (pred_mem[rd_ptr] != resolve_taken);

    // Entry storage needs no reset: validity is tracked entirely by pointers and count.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            pc_mem[wr_ptr]   <= alloc_pc;
            pred_mem[wr_ptr] <= alloc_pred;
            ghr_mem[wr_ptr]  <= alloc_ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            upd_valid  <= 1'b0;
            mispredict <= 1'b0;
            upd_pc     <= '0;
            upd_taken  <= 1'b0;
            upd_ghr    <= '0;
            repair_ghr <= '0;
            underflow  <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A mispredict discards every younger entry, including one allocated this cycle.
            if (head_mis) begin
                wr_ptr <= rd_ptr + PW'(1);
                count  <= '0;
            end else begin
                if (do_alloc) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                case ({do_alloc, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            upd_valid  <= do_pop;
            mispredict <= head_mis;
            if (do_pop) begin
                upd_pc     <= pc_mem[rd_ptr];
                upd_taken  <= resolve_taken;
                upd_ghr    <= ghr_mem[rd_ptr];
                repair_ghr <= {ghr_mem[rd_ptr][GHR_WIDTH-2:0], resolve_taken};
            end

            if (resolve_valid && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef BOQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid && (stat_resolved != 16'hFFFF)) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (mispredict && (stat_mispred != 16'hFFFF)) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_outcome_queue.sv
// Self-checking bench for branch_outcome_queue against a queue-based reference model.
// Statistics checks are compiled in when BOQ_STATS_EN is defined.
module tb_branch_outcome_queue;

    localparam int PW = 8;
    localparam int GW = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [PW-1:0] alloc_pc;
    logic          alloc_pred;
    logic [GW-1:0] alloc_ghr;
    logic          resolve_valid;
    logic          resolve_taken;
    logic          upd_valid;
    logic [PW-1:0] upd_pc;
    logic          upd_taken;
    logic [GW-1:0] upd_ghr;
    logic          mispredict;
    logic [GW-1:0] repair_ghr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          underflow;
`ifdef BOQ_STATS_EN
    logic [15:0]   stat_resolved;
    logic [15:0]   stat_mispred;
    int            exp_sres;
    int            exp_smis;
`endif

    branch_outcome_queue #(.PC_WIDTH(PW), .GHR_WIDTH(GW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_pred(alloc_pred), .alloc_ghr(alloc_ghr),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
        .mispredict(mispredict), .repair_ghr(repair_ghr),
        .count(count), .full(full), .empty(empty), .underflow(underflow)
`ifdef BOQ_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic          pred;
        logic [GW-1:0] ghr;
    } ent_t;

    ent_t q[$];
    logic          exp_uv, exp_mis, exp_taken, exp_under;
    logic [PW-1:0] exp_pc;
    logic [GW-1:0] exp_ghr, exp_repair;
    int n_cmp = 0;
    int n_fail = 0;

    // Reference model advances on the upcoming edge, then the DUT is sampled 1 ns after it.
    task automatic cycle();
        bit   acc;
        bit   pop;
        ent_t e;
        if (reset) begin
            q.delete();
            exp_uv = 0; exp_mis = 0; exp_taken = 0; exp_under = 0;
            exp_pc = '0; exp_ghr = '0; exp_repair = '0;
`ifdef BOQ_STATS_EN
            exp_sres = 0; exp_smis = 0;
`endif
        end else begin
            acc = alloc_valid && (q.size() < DEPTH);
            pop = resolve_valid && (q.size() > 0);
            if (resolve_valid && q.size() == 0) exp_under = 1;
            exp_uv  = pop;
            exp_mis = 0;
            if (pop) begin
                e = q.pop_front();
                exp_pc     = e.pc;
                exp_ghr    = e.ghr;
                exp_taken  = resolve_taken;
                exp_repair = {e.ghr[GW-2:0], resolve_taken};
                exp_mis    = (e.pred != resolve_taken);
`ifdef BOQ_STATS_EN
                if (exp_sres < 65535) exp_sres++;
                if (exp_mis && exp_smis < 65535) exp_smis++;
`endif
            end
            if (exp_mis) q.delete();
            else if (acc) q.push_back('{alloc_pc, alloc_pred, alloc_ghr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; alloc_valid = 0; alloc_pc = '0; alloc_pred = 0; alloc_ghr = '0;
        resolve_valid = 0; resolve_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (count !== '0)         begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1)       begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0)        begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", alloc_ready); end
        n_cmp++; if ({upd_valid, mispredict, underflow} !== 3'b000)
            begin n_fail++; $display("FAIL reset_flags got %b want 000", {upd_valid, mispredict, underflow}); end
        n_cmp++; if ({upd_pc, upd_taken, upd_ghr, repair_ghr} !== '0)
            begin n_fail++; $display("FAIL reset_data got %h want 0", {upd_pc, upd_taken, upd_ghr, repair_ghr}); end
    endtask

    task automatic test_basic();
        do_reset();
        alloc_valid = 1; alloc_pc = 8'h10; alloc_pred = 1; alloc_ghr = 8'h00;
        cycle();
        alloc_valid = 0;
        resolve_valid = 1; resolve_taken = 1;
        cycle();
        resolve_valid = 0;
        n_cmp++; if (upd_valid !== 1'b1)  begin n_fail++; $display("FAIL basic_upd_valid got %b want 1", upd_valid); end
        n_cmp++; if (upd_pc !== 8'h10)    begin n_fail++; $display("FAIL basic_upd_pc got %h want 10", upd_pc); end
        n_cmp++; if (upd_taken !== 1'b1)  begin n_fail++; $display("FAIL basic_upd_taken got %b want 1", upd_taken); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_mispredict got %b want 0", mispredict); end
        n_cmp++; if (count !== '0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL basic_empty got count=%0d empty=%b want 0/1", count, empty); end
        cycle();
        n_cmp++; if (upd_valid !== 1'b0)  begin n_fail++; $display("FAIL basic_pulse got %b want 0", upd_valid); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        // Offset the pointers so the drain crosses the wrap point.
        for (int r = 0; r < 3; r++) begin
            alloc_valid = 1; alloc_pred = 0; alloc_pc = 8'hF0;
            cycle();
            alloc_valid = 0; resolve_valid = 1; resolve_taken = 0;
            cycle();
            resolve_valid = 0;
        end
        for (int i = 0; i < 9; i++) begin
            alloc_valid = 1; alloc_pc = PW'(i); alloc_pred = 1; alloc_ghr = GW'(i * 3);
            cycle();
        end
        alloc_valid = 0;
        n_cmp++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== CW'(8))
            begin n_fail++; $display("FAIL fill_full got full=%b ready=%b count=%0d want 1/0/8", full, alloc_ready, count); end
        for (int i = 0; i < 8; i++) begin
            resolve_valid = 1; resolve_taken = 1;
            cycle();
            n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== PW'(i) || upd_ghr !== exp_ghr)
                begin n_fail++; $display("FAIL drain_%0d got v=%b pc=%h ghr=%h want 1/%h/%h", i, upd_valid, upd_pc, upd_ghr, i, exp_ghr); end
        end
        resolve_valid = 0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_valid = 1; alloc_pc = 8'hA0; alloc_pred = 1; alloc_ghr = 8'h5A; cycle();
        alloc_pc = 8'hA1; alloc_ghr = 8'h11; cycle();
        alloc_pc = 8'hA2; alloc_ghr = 8'h22; cycle();
        alloc_valid = 0;
        resolve_valid = 1; resolve_taken = 0;
        cycle();
        resolve_valid = 0;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", mispredict); end
        n_cmp++; if (repair_ghr !== 8'hB4) begin n_fail++; $display("FAIL mis_repair got %h want b4", repair_ghr); end
        n_cmp++; if (upd_ghr !== 8'h5A)    begin n_fail++; $display("FAIL mis_upd_ghr got %h want 5a", upd_ghr); end
        n_cmp++; if (count !== '0 || alloc_ready !== 1'b1)
            begin n_fail++; $display("FAIL mis_flush got count=%0d ready=%b want 0/1", count, alloc_ready); end
        resolve_valid = 1; resolve_taken = 1;
        cycle(); cycle();
        resolve_valid = 0;
        n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL mis_no_upd got %b want 0", upd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_pc = PW'(8'h40 + i); alloc_pred = 1; alloc_ghr = GW'(i);
            cycle();
        end
        resolve_valid = 1; resolve_taken = 1; alloc_pc = 8'h50;
        cycle();
        n_cmp++; if (count !== CW'(4)) begin n_fail++; $display("FAIL b2b_count got %0d want 4", count); end
        n_cmp++; if (upd_pc !== 8'h40) begin n_fail++; $display("FAIL b2b_pc got %h want 40", upd_pc); end
        resolve_taken = 0; alloc_pc = 8'h51;
        cycle();
        alloc_valid = 0;
        n_cmp++; if (count !== '0 || mispredict !== 1'b1)
            begin n_fail++; $display("FAIL b2b_flush got count=%0d mis=%b want 0/1", count, mispredict); end
        resolve_taken = 1;
        cycle();
        resolve_valid = 0;
        n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dropped got %b want 0", upd_valid); end
    endtask

    task automatic test_underflow_reset();
        do_reset();
        resolve_valid = 1; resolve_taken = 1;
        cycle();
        resolve_valid = 0;
        n_cmp++; if (upd_valid !== 1'b0 || underflow !== 1'b1)
            begin n_fail++; $display("FAIL uf_set got v=%b uf=%b want 0/1", upd_valid, underflow); end
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1; alloc_pc = PW'(i); alloc_pred = 1;
            cycle();
        end
        alloc_valid = 0;
        n_cmp++; if (underflow !== 1'b1 || count !== CW'(5))
            begin n_fail++; $display("FAIL uf_hold got uf=%b count=%0d want 1/5", underflow, count); end
        reset = 1; resolve_valid = 1; resolve_taken = 0;
        cycle();
        reset = 0; resolve_valid = 0;
        n_cmp++; if (count !== '0 || upd_valid !== 1'b0 || underflow !== 1'b0 || mispredict !== 1'b0)
            begin n_fail++; $display("FAIL uf_reset got count=%0d v=%b uf=%b mis=%b want 0/0/0/0", count, upd_valid, underflow, mispredict); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            alloc_valid   = ($urandom_range(0, 2) != 0);
            alloc_pc      = PW'($urandom);
            alloc_pred    = 1'($urandom);
            alloc_ghr     = GW'($urandom);
            resolve_valid = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 7) != 0) resolve_taken = q[0].pred;
            else resolve_taken = 1'($urandom);
            cycle();
            n_cmp++;
            if (upd_valid !== exp_uv || mispredict !== exp_mis || count !== CW'(q.size()) ||
                full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || underflow !== exp_under ||
                upd_pc !== exp_pc || upd_taken !== exp_taken || upd_ghr !== exp_ghr || repair_ghr !== exp_repair) begin
                n_fail++;
                $display("FAIL rand_%0d got v=%b m=%b n=%0d f=%b e=%b u=%b pc=%h t=%b g=%h r=%h want v=%b m=%b n=%0d u=%b pc=%h t=%b g=%h r=%h",
                         c, upd_valid, mispredict, count, full, empty, underflow, upd_pc, upd_taken, upd_ghr, repair_ghr,
                         exp_uv, exp_mis, q.size(), exp_under, exp_pc, exp_taken, exp_ghr, exp_repair);
            end
        end
        idle_inputs();
    endtask

`ifdef BOQ_STATS_EN
    task automatic test_stats();
        logic [9:0] pattern;
        do_reset();
        pattern = 10'b0100100100;
        for (int i = 0; i < 10; i++) begin
            alloc_valid = 1; alloc_pc = PW'(i); alloc_pred = 1;
            cycle();
            alloc_valid = 0;
            resolve_valid = 1; resolve_taken = !pattern[i];
            cycle();
            resolve_valid = 0;
        end
        cycle(); cycle();
        n_cmp++; if (stat_resolved !== 16'd10 || stat_resolved !== 16'(exp_sres))
            begin n_fail++; $display("FAIL stat_resolved got %0d want 10", stat_resolved); end
        n_cmp++; if (stat_mispred !== 16'd3 || stat_mispred !== 16'(exp_smis))
            begin n_fail++; $display("FAIL stat_mispred got %0d want 3", stat_mispred); end
        alloc_valid = 1; alloc_pred = 1; alloc_pc = 8'h77;
        cycle();
        resolve_valid = 1; resolve_taken = 1;
        for (int i = 0; i < 65540; i++) cycle();
        idle_inputs();
        cycle(); cycle();
        n_cmp++; if (stat_resolved !== 16'hFFFF)
            begin n_fail++; $display("FAIL stat_saturate got %h want ffff", stat_resolved); end
        n_cmp++; if (stat_mispred !== 16'd3)
            begin n_fail++; $display("FAIL stat_mis_hold got %0d want 3", stat_mispred); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_fill_wrap();
        test_mispredict();
        test_back_to_back();
        test_underflow_reset();
        test_random();
`ifdef BOQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
